// File: rtl/jk_driver.sv
// Purpose: queues target bits and drives J/K excitation so an external JK flip-flop reaches each target, then verifies it.
// Latency: bit accepted at edge N -> J/K driven in cycle N+1, done (and mismatch) in cycle N+2; one bit per 2 cycles sustained.
// Backpressure: in_ready drops while the DEPTH-entry target queue is full; in_valid is ignored then.
module jk_driver #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             q,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             target;

    logic             push;
    logic             pop;
    logic             head;
    logic             fifo_empty;
    logic [1:0]       head_jk;

    // JK excitation: set when going 0->1, reset when going 1->0, otherwise hold.
    // The don't-care cases resolve to 0 so J=K=1 (toggle) is never driven.
    function automatic logic [1:0] excite(input logic cur, input logic tgt);
        excite = {~cur & tgt, cur & ~tgt};
    endfunction

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    // A bit is consumed only from IDLE or on leaving CHECK; count is registered,
    // so a bit pushed on this edge cannot be popped on the same edge.
    assign pop        = ((state == IDLE) || (state == CHECK)) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign head_jk    = excite(q, head);

    assign busy       = (state != IDLE) || !fifo_empty;
    // q is only meaningful after the flip-flop's capture edge, i.e. during CHECK,
    // so the comparison is made live against the held target.
    assign mismatch   = done && (q != target);

    // Target-bit queue: circular buffer with natural pointer wrap (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_bit;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: IDLE -> DRIVE (one cycle of J/K) -> CHECK (done, compare) -> DRIVE/IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
            target    <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (pop) begin
                        target <= head;
                        j      <= head_jk[1];
                        k      <= head_jk[0];
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The flip-flop captures J/K on this edge; release them and verify next cycle.
                    j     <= 1'b0;
                    k     <= 1'b0;
                    done  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    if ((q != target) && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (pop) begin
                        target <= head;
                        j      <= head_jk[1];
                        k      <= head_jk[0];
                        state  <= DRIVE;
                    end else begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jk_driver.md
JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 Parameter DEPTH, default 4, target-bit FIFO depth; SHALL be a power of 2, >= 2.
REQ-002 Parameter ERR_W, default 8, width of the mismatch counter.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  target bit offered.
REQ-006 in_bit  input  1  desired next flip-flop state.
REQ-007 in_ready  output  1  high when FIFO not full.
REQ-008 q  input  1  current state fed back from the driven JK flip-flop.
REQ-009 j  output  1  J excitation to the flip-flop, registered.
REQ-010 k  output  1  K excitation to the flip-flop, registered.
REQ-011 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-012 done  output  1  one-cycle pulse per completed target bit.
REQ-013 mismatch  output  1  one-cycle pulse, coincident with done, when check fails.
REQ-014 err_count  output  ERR_W  saturating count of mismatches.

Function
REQ-015 Push SHALL occur on an edge with in_valid && in_ready; in_bit is stored at the FIFO tail.
REQ-016 in_ready SHALL equal (count != DEPTH); no push when full, in_valid ignored.
REQ-017 FSM states SHALL be IDLE, DRIVE, CHECK; encoding is free.
REQ-018 IDLE: j=k=0; if FIFO non-empty, the edge SHALL pop the head into a target register, set j/k from excitation(q, head), and enter DRIVE.
REQ-019 Excitation SHALL be: q=0,t=0 -> j=0,k=0; q=0,t=1 -> j=1,k=0; q=1,t=0 -> j=0,k=1; q=1,t=1 -> j=0,k=0 (don't-cares resolved to 0; j=k=1 never driven).
REQ-020 DRIVE SHALL last exactly one cycle, j/k held; the next edge (the flip-flop's capture edge) SHALL set j=k=0 and enter CHECK.
REQ-021 CHECK SHALL last one cycle, assert done, and compare q with the target register; on q != target, mismatch=1.
REQ-022 On mismatch, err_count SHALL increment by 1 at the CHECK-exit edge, saturating at 2^ERR_W-1.
REQ-023 CHECK exit: FIFO non-empty -> pop, load j/k per REQ-019 from current q, enter DRIVE; empty -> IDLE.
REQ-024 Throughput SHALL be one target bit per 2 cycles when the FIFO is never empty.
REQ-025 Latency: bit pushed at edge N into an empty, idle block -> DRIVE during cycle N+1..N+2, done high in cycle N+2..N+3.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-027 A push in the same cycle as FIFO empty with FSM in IDLE SHALL NOT be popped until the following edge (no fall-through).
REQ-028 Every accepted bit SHALL produce exactly one done pulse, in acceptance order; no bit dropped or duplicated.

Reset
REQ-029 reset SHALL have priority over all other activity, including push, pop, and counter increment on the same edge.
REQ-030 After reset: state=IDLE, FIFO empty, pointers 0, j=0, k=0, done=0, mismatch=0, err_count=0, busy=0, in_ready=1.
REQ-031 Reset during DRIVE or CHECK SHALL abort the bit in flight with no done pulse and discard all queued bits.

Verification
REQ-032 Reset, then push 1,0,1,1 with q from a correct JK flip-flop model starting at 0 -> j/k in DRIVE = (1,0),(0,1),(1,0),(0,0); four done pulses; mismatch never; err_count=0.
REQ-033 Push 5 bits back-to-back with in_valid held, DEPTH=4, FSM stalled -> in_ready low after 4 FIFO entries; 5th accepted only after first pop; done order matches push order.
REQ-034 q tied to 0, push 1,1,1 -> three mismatch pulses coincident with done; err_count=3.
REQ-035 ERR_W=2, q tied to 0, push six 1s -> err_count saturates at 3, no wrap to 0.
REQ-036 Push 3 bits, assert reset for one cycle during the first DRIVE -> j=k=0, busy=0, in_ready=1 next cycle; no done pulse afterward.
REQ-037 Continuous push/pop for 20 bits -> done every second cycle; FIFO count never exceeds 1 after startup; pointer wrap verified.
